// File: rtl/german_pkg.sv
`default_nettype none
// ============================================================================
// Module      : german_pkg
// Description : Shared encodings, rule-kind indices and record types for the
//               parametrised German cache-coherence system model.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package german_pkg;

  typedef enum logic [1:0] {
    CACHE_I = 2'd0,
    CACHE_S = 2'd1,
    CACHE_E = 2'd2
  } cache_state_e;

  typedef enum logic [2:0] {
    CMD_EMPTY  = 3'd0,
    CMD_REQS   = 3'd1,
    CMD_REQE   = 3'd2,
    CMD_INV    = 3'd3,
    CMD_INVACK = 3'd4,
    CMD_GNTS   = 3'd5,
    CMD_GNTE   = 3'd6
  } cmd_e;

  localparam int RULE_KINDS = 12;

  // Record data fields are sized for the widest supported DATA_W; narrower
  // configurations zero-extend, so the upper bits stay constant zero.
  localparam int DATA_W_MAX = 8;

  localparam int K_SEND_REQS   = 0;
  localparam int K_SEND_REQE   = 1;
  localparam int K_RECV_REQS   = 2;
  localparam int K_RECV_REQE   = 3;
  localparam int K_SEND_INV    = 4;
  localparam int K_SEND_INVACK = 5;
  localparam int K_RECV_INVACK = 6;
  localparam int K_SEND_GNTS   = 7;
  localparam int K_SEND_GNTE   = 8;
  localparam int K_RECV_GNTS   = 9;
  localparam int K_RECV_GNTE   = 10;
  localparam int K_STORE       = 11;

  typedef struct packed {
    cmd_e                  cmd;
    logic [DATA_W_MAX-1:0] data;
  } msg_t;

  typedef struct packed {
    cache_state_e          state;
    logic [DATA_W_MAX-1:0] data;
  } cache_t;

  // Rule-select code for a given rule kind and node.
  function automatic int rule_en(input int kind, input int node, input int node_num);
    return kind * node_num + node;
  endfunction

endpackage
`default_nettype wire

// File: rtl/german_node_guard.sv
`default_nettype none
// ============================================================================
// Module      : german_node_guard
// Description : Per-node rule-select decode and guard evaluation for the 12
//               German rule kinds. fire[k] is high when kind k is selected
//               for this node and its guard holds.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module german_node_guard
  import german_pkg::*;
#(
  parameter int NODE_NUM = 3,
  parameter int NODE_ID  = 0,
  parameter int EN_W     = 6
) (
  input  logic [EN_W-1:0]       en,
  input  cache_state_e          cache_state,
  input  cmd_e                  chan1_cmd,
  input  cmd_e                  chan2_cmd,
  input  cmd_e                  chan3_cmd,
  input  logic                  inv_bit,
  input  cmd_e                  cur_cmd,
  input  logic                  cur_ptr_hit,
  input  logic                  ex_gntd,
  input  logic                  shr_empty,
  output logic [RULE_KINDS-1:0] fire
);

  logic [RULE_KINDS-1:0] sel;
  logic [RULE_KINDS-1:0] guard;

  for (genvar k = 0; k < RULE_KINDS; k++) begin : g_sel
    assign sel[k] = (en == EN_W'(rule_en(k, NODE_ID, NODE_NUM)));
  end

  // Guard predicates of every rule kind as seen from this node.
  always_comb begin
    guard = '0;
    guard[K_SEND_REQS]   = (chan1_cmd == CMD_EMPTY) && (cache_state == CACHE_I);
    guard[K_SEND_REQE]   = (chan1_cmd == CMD_EMPTY) &&
                           ((cache_state == CACHE_I) || (cache_state == CACHE_S));
    guard[K_RECV_REQS]   = (cur_cmd == CMD_EMPTY) && (chan1_cmd == CMD_REQS);
    guard[K_RECV_REQE]   = (cur_cmd == CMD_EMPTY) && (chan1_cmd == CMD_REQE);
    guard[K_SEND_INV]    = (chan2_cmd == CMD_EMPTY) && inv_bit &&
                           ((cur_cmd == CMD_REQE) || ((cur_cmd == CMD_REQS) && ex_gntd));
    guard[K_SEND_INVACK] = (chan2_cmd == CMD_INV) && (chan3_cmd == CMD_EMPTY);
    guard[K_RECV_INVACK] = (chan3_cmd == CMD_INVACK) && (cur_cmd != CMD_EMPTY);
    guard[K_SEND_GNTS]   = (cur_cmd == CMD_REQS) && cur_ptr_hit &&
                           (chan2_cmd == CMD_EMPTY) && !ex_gntd;
    guard[K_SEND_GNTE]   = (cur_cmd == CMD_REQE) && cur_ptr_hit &&
                           (chan2_cmd == CMD_EMPTY) && !ex_gntd && shr_empty;
    guard[K_RECV_GNTS]   = (chan2_cmd == CMD_GNTS);
    guard[K_RECV_GNTE]   = (chan2_cmd == CMD_GNTE);
    guard[K_STORE]       = (cache_state == CACHE_E);
  end

  assign fire = sel & guard;

endmodule
`default_nettype wire

// File: rtl/german_system_param.sv
`default_nettype none
// ============================================================================
// Module      : german_system_param
// Description : Parametrised German cache-coherence system. One guarded rule,
//               selected by io_en_a, fires atomically per clock. Provides a
//               fired flag and registered control/data invariants.
//               Optional macro GERMAN_DATA_PROP_EN adds the AuxData shadow
//               register and a live data invariant; otherwise io_data_prop
//               is constant 1.
//               DATA_W must not exceed german_pkg::DATA_W_MAX.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module german_system_param
  import german_pkg::*;
#(
  parameter int NODE_NUM = 3,
  parameter int DATA_W   = 2,
  parameter int EN_W     = $clog2(12*NODE_NUM+1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [EN_W-1:0]       io_en_a,
  input  logic [DATA_W-1:0]     io_store_data,
  output logic                  io_fired,
  output logic                  io_ctrl_prop,
  output logic                  io_data_prop,
  output logic [2*NODE_NUM-1:0] io_cache_state
);

  localparam int PTR_W = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;

  cache_t [NODE_NUM-1:0] cache_q, cache_d;
  cmd_e                  chan1_q [NODE_NUM];
  cmd_e                  chan1_d [NODE_NUM];
  msg_t  [NODE_NUM-1:0]  chan2_q, chan2_d;
  msg_t  [NODE_NUM-1:0]  chan3_q, chan3_d;
  logic  [NODE_NUM-1:0]  inv_set_q, inv_set_d;
  logic  [NODE_NUM-1:0]  shr_set_q, shr_set_d;
  logic                  ex_gntd_q, ex_gntd_d;
  cmd_e                  cur_cmd_q, cur_cmd_d;
  logic [PTR_W-1:0]      cur_ptr_q, cur_ptr_d;
  logic [DATA_W_MAX-1:0] mem_data_q, mem_data_d;
  logic                  fired_d;
  logic                  ctrl_ok;
  logic                  data_ok;
  logic                  fired_q, ctrl_prop_q, data_prop_q;
  logic [RULE_KINDS-1:0] fire [NODE_NUM];

  for (genvar g = 0; g < NODE_NUM; g++) begin : g_node
    german_node_guard #(
      .NODE_NUM (NODE_NUM),
      .NODE_ID  (g),
      .EN_W     (EN_W)
    ) u_guard (
      .en          (io_en_a),
      .cache_state (cache_q[g].state),
      .chan1_cmd   (chan1_q[g]),
      .chan2_cmd   (chan2_q[g].cmd),
      .chan3_cmd   (chan3_q[g].cmd),
      .inv_bit     (inv_set_q[g]),
      .cur_cmd     (cur_cmd_q),
      .cur_ptr_hit (cur_ptr_q == PTR_W'(g)),
      .ex_gntd     (ex_gntd_q),
      .shr_empty   (shr_set_q == '0),
      .fire        (fire[g])
    );
    assign io_cache_state[2*g +: 2] = cache_q[g].state;
  end

  // Apply the updates of the (at most one) firing rule to form next state.
  always_comb begin
    cache_d    = cache_q;
    chan1_d    = chan1_q;
    chan2_d    = chan2_q;
    chan3_d    = chan3_q;
    inv_set_d  = inv_set_q;
    shr_set_d  = shr_set_q;
    ex_gntd_d  = ex_gntd_q;
    cur_cmd_d  = cur_cmd_q;
    cur_ptr_d  = cur_ptr_q;
    mem_data_d = mem_data_q;
    fired_d    = 1'b0;
    for (int i = 0; i < NODE_NUM; i++) begin
      fired_d = fired_d | (|fire[i]);
      if (fire[i][K_SEND_REQS]) chan1_d[i] = CMD_REQS;
      if (fire[i][K_SEND_REQE]) chan1_d[i] = CMD_REQE;
      if (fire[i][K_RECV_REQS] || fire[i][K_RECV_REQE]) begin
        cur_cmd_d  = chan1_q[i];
        cur_ptr_d  = PTR_W'(i);
        chan1_d[i] = CMD_EMPTY;
        inv_set_d  = shr_set_q;
      end
      if (fire[i][K_SEND_INV]) begin
        chan2_d[i].cmd = CMD_INV;
        inv_set_d[i]   = 1'b0;
      end
      if (fire[i][K_SEND_INVACK]) begin
        chan2_d[i].cmd = CMD_EMPTY;
        chan3_d[i].cmd = CMD_INVACK;
        if (cache_q[i].state == CACHE_E) chan3_d[i].data = cache_q[i].data;
        cache_d[i].state = CACHE_I;
      end
      if (fire[i][K_RECV_INVACK]) begin
        chan3_d[i].cmd = CMD_EMPTY;
        shr_set_d[i]   = 1'b0;
        if (ex_gntd_q) begin
          ex_gntd_d  = 1'b0;
          mem_data_d = chan3_q[i].data;
        end
      end
      if (fire[i][K_SEND_GNTS]) begin
        chan2_d[i]   = '{cmd: CMD_GNTS, data: mem_data_q};
        shr_set_d[i] = 1'b1;
        cur_cmd_d    = CMD_EMPTY;
      end
      if (fire[i][K_SEND_GNTE]) begin
        chan2_d[i]   = '{cmd: CMD_GNTE, data: mem_data_q};
        shr_set_d[i] = 1'b1;
        ex_gntd_d    = 1'b1;
        cur_cmd_d    = CMD_EMPTY;
      end
      if (fire[i][K_RECV_GNTS]) begin
        cache_d[i]     = '{state: CACHE_S, data: chan2_q[i].data};
        chan2_d[i].cmd = CMD_EMPTY;
      end
      if (fire[i][K_RECV_GNTE]) begin
        cache_d[i]     = '{state: CACHE_E, data: chan2_q[i].data};
        chan2_d[i].cmd = CMD_EMPTY;
      end
      if (fire[i][K_STORE]) cache_d[i].data = DATA_W_MAX'(io_store_data);
    end
  end

  // Control invariant on next state: an exclusive copy excludes all others.
  always_comb begin
    ctrl_ok = 1'b1;
    for (int i = 0; i < NODE_NUM; i++) begin
      for (int j = 0; j < NODE_NUM; j++) begin
        if (i != j) begin
          if ((cache_d[i].state == CACHE_E) && (cache_d[j].state != CACHE_I)) ctrl_ok = 1'b0;
          if ((cache_d[i].state == CACHE_S) && (cache_d[j].state == CACHE_E)) ctrl_ok = 1'b0;
        end
      end
    end
  end

`ifdef GERMAN_DATA_PROP_EN
  logic [DATA_W_MAX-1:0] aux_data_q, aux_data_d;

  // AuxData tracks the most recent value written by any Store.
  always_comb begin
    aux_data_d = aux_data_q;
    for (int i = 0; i < NODE_NUM; i++) begin
      if (fire[i][K_STORE]) aux_data_d = DATA_W_MAX'(io_store_data);
    end
  end

  // Data invariant on next state: memory and valid copies hold the latest store.
  always_comb begin
    data_ok = ex_gntd_d || (mem_data_d == aux_data_d);
    for (int i = 0; i < NODE_NUM; i++) begin
      if ((cache_d[i].state != CACHE_I) && (cache_d[i].data != aux_data_d)) data_ok = 1'b0;
    end
  end

  // AuxData register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) aux_data_q <= '0;
    else        aux_data_q <= aux_data_d;
  end
`else
  assign data_ok = 1'b1;
`endif

  // System state and registered status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cache_q     <= '0;
      chan2_q     <= '0;
      chan3_q     <= '0;
      for (int i = 0; i < NODE_NUM; i++) chan1_q[i] <= CMD_EMPTY;
      inv_set_q   <= '0;
      shr_set_q   <= '0;
      ex_gntd_q   <= 1'b0;
      cur_cmd_q   <= CMD_EMPTY;
      cur_ptr_q   <= '0;
      mem_data_q  <= '0;
      fired_q     <= 1'b0;
      ctrl_prop_q <= 1'b1;
      data_prop_q <= 1'b1;
    end else begin
      cache_q     <= cache_d;
      chan1_q     <= chan1_d;
      chan2_q     <= chan2_d;
      chan3_q     <= chan3_d;
      inv_set_q   <= inv_set_d;
      shr_set_q   <= shr_set_d;
      ex_gntd_q   <= ex_gntd_d;
      cur_cmd_q   <= cur_cmd_d;
      cur_ptr_q   <= cur_ptr_d;
      mem_data_q  <= mem_data_d;
      fired_q     <= fired_d;
      ctrl_prop_q <= ctrl_ok;
      data_prop_q <= data_ok;
    end
  end

  assign io_fired     = fired_q;
  assign io_ctrl_prop = ctrl_prop_q;
  assign io_data_prop = data_prop_q;

endmodule
`default_nettype wire

// File: tb/tb_german_system_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_german_system_param
// Description : Scoreboard bench for german_system_param (NODE_NUM=3,
//               DATA_W=2). A behavioural protocol model predicts each step;
//               predictions are queued at drive time and compared after the
//               edge. Directed protocol walk, random rules, resets and
//               backdoor invariant violations. Honours GERMAN_DATA_PROP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_german_system_param;
  import german_pkg::*;

  localparam int N  = 3;
  localparam int DW = 2;
  localparam int EW = $clog2(12*N+1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [EW-1:0] io_en_a = '0;
  logic [DW-1:0] io_store_data = '0;
  logic          io_fired, io_ctrl_prop, io_data_prop;
  logic [2*N-1:0] io_cache_state;

  always #5 clock = ~clock;

  german_system_param #(.NODE_NUM(N), .DATA_W(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_en_a        (io_en_a),
    .io_store_data  (io_store_data),
    .io_fired       (io_fired),
    .io_ctrl_prop   (io_ctrl_prop),
    .io_data_prop   (io_data_prop),
    .io_cache_state (io_cache_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cs [N], m_cd [N], m_c1 [N], m_c2c [N], m_c2d [N], m_c3c [N], m_c3d [N];
  bit [N-1:0] m_inv, m_shr;
  int m_ex, m_cur, m_ptr, m_mem, m_aux;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cs[i] = 0; m_cd[i] = 0; m_c1[i] = 0; m_c2c[i] = 0;
      m_c2d[i] = 0; m_c3c[i] = 0; m_c3d[i] = 0;
    end
    m_inv = '0; m_shr = '0; m_ex = 0; m_cur = 0; m_ptr = 0; m_mem = 0; m_aux = 0;
  endtask

  function automatic bit model_apply(input int en, input int sd);
    int k = en / N;
    int i = en % N;
    bit f = 1'b0;
    if (en < 12*N) begin
      case (k)
        0: if (m_c1[i] == 0 && m_cs[i] == 0) begin m_c1[i] = 1; f = 1; end
        1: if (m_c1[i] == 0 && m_cs[i] != 2) begin m_c1[i] = 2; f = 1; end
        2, 3: if (m_cur == 0 && m_c1[i] == k - 1) begin
          m_cur = k - 1; m_ptr = i; m_c1[i] = 0; m_inv = m_shr; f = 1;
        end
        4: if (m_c2c[i] == 0 && m_inv[i] && (m_cur == 2 || (m_cur == 1 && m_ex != 0))) begin
          m_c2c[i] = 3; m_inv[i] = 1'b0; f = 1;
        end
        5: if (m_c2c[i] == 3 && m_c3c[i] == 0) begin
          m_c2c[i] = 0; m_c3c[i] = 4;
          if (m_cs[i] == 2) m_c3d[i] = m_cd[i];
          m_cs[i] = 0; f = 1;
        end
        6: if (m_c3c[i] == 4 && m_cur != 0) begin
          m_c3c[i] = 0; m_shr[i] = 1'b0;
          if (m_ex != 0) begin m_ex = 0; m_mem = m_c3d[i]; end
          f = 1;
        end
        7: if (m_cur == 1 && m_ptr == i && m_c2c[i] == 0 && m_ex == 0) begin
          m_c2c[i] = 5; m_c2d[i] = m_mem; m_shr[i] = 1'b1; m_cur = 0; f = 1;
        end
        8: if (m_cur == 2 && m_ptr == i && m_c2c[i] == 0 && m_ex == 0 && m_shr == 0) begin
          m_c2c[i] = 6; m_c2d[i] = m_mem; m_shr[i] = 1'b1; m_ex = 1; m_cur = 0; f = 1;
        end
        9, 10: if (m_c2c[i] == k - 4) begin
          m_cs[i] = k - 8; m_cd[i] = m_c2d[i]; m_c2c[i] = 0; f = 1;
        end
        11: if (m_cs[i] == 2) begin m_cd[i] = sd; m_aux = sd; f = 1; end
        default: f = 1'b0;
      endcase
    end
    return f;
  endfunction

  function automatic bit model_dprop();
`ifdef GERMAN_DATA_PROP_EN
    bit ok = (m_ex != 0) || (m_mem == m_aux);
    for (int i = 0; i < N; i++) if (m_cs[i] != 0 && m_cd[i] != m_aux) ok = 1'b0;
    return ok;
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit             fired;
    logic [2*N-1:0] cs;
    bit             ex;
    logic [N-1:0]   shr;
    logic [DW-1:0]  mem;
    bit             dprop;
  } exp_t;

  exp_t sbq[$];

  task automatic step(input int en, input int sd);
    exp_t e;
    exp_t x;
    io_en_a       = EW'(en);
    io_store_data = DW'(sd);
    e.fired = model_apply(en, sd);
    for (int i = 0; i < N; i++) e.cs[2*i +: 2] = 2'(m_cs[i]);
    e.ex    = (m_ex != 0);
    e.shr   = m_shr;
    e.mem   = DW'(m_mem);
    e.dprop = model_dprop();
    sbq.push_back(e);
    @(posedge clock);
    #1;
    x = sbq.pop_front();
    check("fired",     32'(io_fired),          32'(x.fired));
    check("cache_st",  32'(io_cache_state),    32'(x.cs));
    check("ex_gntd",   32'(dut.ex_gntd_q),     32'(x.ex));
    check("shr_set",   32'(dut.shr_set_q),     32'(x.shr));
    check("mem_data",  32'(dut.mem_data_q),    32'(x.mem));
    check("ctrl_prop", 32'(io_ctrl_prop),      32'd1);
    check("data_prop", 32'(io_data_prop),      32'(x.dprop));
  endtask

  cache_t [N-1:0] frc;

  initial begin
    model_reset();
    // reset with arbitrary inputs applied
    io_en_a = EW'(4);
    io_store_data = 2'b11;
    repeat (3) @(posedge clock);
    #1;
    check("rst_fired",   32'(io_fired),       32'd0);
    check("rst_ctrl",    32'(io_ctrl_prop),   32'd1);
    check("rst_dprop",   32'(io_data_prop),   32'd1);
    check("rst_cache",   32'(io_cache_state), 32'd0);
    check("rst_ex",      32'(dut.ex_gntd_q),  32'd0);
    check("rst_shr",     32'(dut.shr_set_q),  32'd0);
    check("rst_mem",     32'(dut.mem_data_q), 32'd0);
    reset = 1'b1;

    // node1 obtains exclusive ownership
    step(4, 0); check("reqe_fired", 32'(io_fired), 32'd1);
    step(10, 0);
    step(25, 0);
    step(31, 0);
    check("gnte_cache", 32'(io_cache_state), 32'b001000);
    check("gnte_ex",    32'(dut.ex_gntd_q),  32'd1);
    check("gnte_shr",   32'(dut.shr_set_q),  32'b010);

    // store on owner, then store on an invalid node
    step(34, 2);
    check("store_data", 32'(dut.cache_q[1].data), 32'd2);
`ifdef GERMAN_DATA_PROP_EN
    check("store_aux",  32'(dut.aux_data_q), 32'd2);
`endif
    step(33, 1);
    check("store_i_fired", 32'(io_fired), 32'd0);
    check("store_i_data",  32'(dut.cache_q[0].data), 32'd0);

    // node0 shared request forces invalidation of node1
    step(0, 0);
    step(6, 0);
    step(13, 0);
    step(16, 0);
    step(19, 0);
    check("inv_cache", 32'(io_cache_state), 32'd0);
    check("inv_ex",    32'(dut.ex_gntd_q),  32'd0);
    check("inv_mem",   32'(dut.mem_data_q), 32'd2);
    check("inv_shr",   32'(dut.shr_set_q),  32'd0);
    step(21, 0);
    check("gnts_cmd",  32'(dut.chan2_q[0].cmd),  32'(CMD_GNTS));
    check("gnts_data", 32'(dut.chan2_q[0].data), 32'd2);
    step(27, 0);
    check("gnts_cache", 32'(io_cache_state), 32'b000001);

    // no-op select and a false guard (SendGntE with sharers present)
    step(36, 0); check("noop_fired", 32'(io_fired), 32'd0);
    step(5, 0);
    step(11, 0);
    step(26, 0); check("gnte_blocked", 32'(io_fired), 32'd0);

    // random rule sequences against the model
    for (int n = 0; n < 400; n++) step(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)));

    // mid-run reset overrides a firing rule
    reset = 1'b0; #2; reset = 1'b1; model_reset();
    step(0, 0); check("pre_rst_fired", 32'(io_fired), 32'd1);
    io_en_a = EW'(1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_fired", 32'(io_fired), 32'd0);
    check("async_rst_chan1", 32'(dut.chan1_q[0]), 32'(CMD_EMPTY));
    @(posedge clock); #1;
    check("held_rst_chan1", 32'(dut.chan1_q[1]), 32'(CMD_EMPTY));
    check("held_rst_fired", 32'(io_fired), 32'd0);
    reset = 1'b1; model_reset();

    // backdoor control-invariant violation
    frc = '0;
    frc[0].state = CACHE_E;
    frc[2].state = CACHE_S;
    io_en_a = EW'(36);
    force dut.cache_q = frc;
    @(posedge clock); #1;
    check("ctrl_violation", 32'(io_ctrl_prop), 32'd0);
    release dut.cache_q;
    reset = 1'b0; #1;
    check("ctrl_after_rst", 32'(io_ctrl_prop), 32'd1);
    reset = 1'b1;

`ifdef GERMAN_DATA_PROP_EN
    force dut.mem_data_q = 8'd1;
    @(posedge clock); #1;
    check("data_violation", 32'(io_data_prop), 32'd0);
    release dut.mem_data_q;
    reset = 1'b0; #1;
    check("data_after_rst", 32'(io_data_prop), 32'd1);
    reset = 1'b1;
`else
    @(posedge clock); #1;
    check("data_tied", 32'(io_data_prop), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
